// File: rtl/bram_stage_sequencer.sv
// rtl/bram_stage_sequencer.sv - sequenced owner of the shared XY-bin BRAM port
//
// Runs NUM_STAGES clients in order, handing the single BRAM port to one client
// at a time. Each client gets a one-cycle start pulse. It keeps the port until
// it raises done. A one-cycle gap with writes gated off separates two owners.
// A per-stage watchdog parks the sequence in FAULT. The last stage is the
// display reader: it owns the port read-only whenever nothing else runs.
module bram_stage_sequencer #(
  parameter int                    NUM_STAGES     = 3,
  parameter int                    ADDR_W         = 19,
  parameter int                    DATA_W         = 3,
  parameter logic [NUM_STAGES-1:0] RO_MASK        = 3'b100,
  parameter int                    TIMEOUT_CYCLES = 50_000_000,
  parameter int                    SEL_W          = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_din,
  input  logic [NUM_STAGES-1:0]        stage_we,
  input  logic [NUM_STAGES-1:0]        stage_done,
  output logic [NUM_STAGES-1:0]        stage_start,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic [DATA_W-1:0]            bram_din,
  output logic                         bram_we,
  output logic [SEL_W-1:0]             active_stage,
  output logic                         busy,
  output logic                         error
);

  // Timer must be able to hold TIMEOUT_CYCLES itself so it never wraps in RUN.
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SEL_W-1:0]   LAST_STAGE = SEL_W'(NUM_STAGES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_GAP,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   k;
  logic [TIMER_W-1:0] timer;
  logic               done_prev;

  logic               sel_we;
  logic               sel_ro;
  logic               done_k;
  logic               done_edge;
  logic               timeout_hit;

  // Port mux keyed on the registered owner; purely combinational so client
  // read addresses reach the BRAM with no added latency.
  always_comb begin
    bram_addr = '0;
    bram_din  = '0;
    sel_we    = 1'b0;
    sel_ro    = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (active_stage == SEL_W'(i)) begin
        bram_addr = stage_addr[i*ADDR_W +: ADDR_W];
        bram_din  = stage_din[i*DATA_W +: DATA_W];
        sel_we    = stage_we[i];
        sel_ro    = RO_MASK[i];
      end
    end
  end

  // Writes only pass while the owner is actually running; START, GAP, HOLD,
  // IDLE and FAULT all leave the BRAM untouched.
  assign bram_we = sel_we & ~sel_ro & (state == S_RUN);

  // Done level of the stage being sequenced (k, not the display owner).
  always_comb begin
    done_k = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (k == SEL_W'(i)) begin
        done_k = stage_done[i];
      end
    end
  end

  // A stale done level from an earlier run must not count, so only a rising
  // edge is accepted.
  assign done_edge   = done_k & ~done_prev;
  assign timeout_hit = (timer == TIMER_LAST);

  // Sequencer FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      k            <= '0;
      active_stage <= LAST_STAGE;
      stage_start  <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
      timer        <= '0;
      done_prev    <= 1'b0;
    end else begin
      stage_start <= '0;
      case (state)
        S_IDLE, S_HOLD, S_FAULT: begin
          if (go) begin
            state        <= S_START;
            k            <= '0;
            active_stage <= '0;
            stage_start  <= NUM_STAGES'(1);
            busy         <= 1'b1;
            error        <= 1'b0;
            timer        <= '0;
          end
        end

        S_START: begin
          done_prev <= done_k;
          if (k == LAST_STAGE) begin
            state <= S_HOLD;
            busy  <= 1'b0;
          end else begin
            state <= S_RUN;
          end
        end

        S_RUN: begin
          done_prev <= done_k;
          if (done_edge) begin
            state <= S_GAP;
          end else if (timeout_hit) begin
            state        <= S_FAULT;
            error        <= 1'b1;
            busy         <= 1'b0;
            active_stage <= LAST_STAGE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        S_GAP: begin
          state        <= S_START;
          k            <= k + SEL_W'(1);
          active_stage <= k + SEL_W'(1);
          stage_start  <= NUM_STAGES'(1) << (k + SEL_W'(1));
          timer        <= '0;
        end

        default: begin
          state        <= S_IDLE;
          active_stage <= LAST_STAGE;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stage_sequencer.sv
// tb/tb_bram_stage_sequencer.sv - self-checking bench for bram_stage_sequencer
module tb_bram_stage_sequencer;

  localparam int NS = 3;
  localparam int AW = 19;
  localparam int DW = 3;
  localparam int TO = 128;

  logic               clk = 1'b0;
  logic               reset;
  logic               go;
  logic [NS*AW-1:0]   stage_addr;
  logic [NS*DW-1:0]   stage_din;
  logic [NS-1:0]      stage_we;
  logic [NS-1:0]      stage_done;
  logic [NS-1:0]      stage_start;
  logic [AW-1:0]      bram_addr;
  logic [DW-1:0]      bram_din;
  logic               bram_we;
  logic [1:0]         active_stage;
  logic               busy;
  logic               error;

  logic [AW-1:0] a [NS];
  logic [DW-1:0] dv[NS];
  logic [NS-1:0] w;
  logic [NS-1:0] done_r;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  bram_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .RO_MASK(3'b100),
    .TIMEOUT_CYCLES(TO), .SEL_W(2)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .stage_addr(stage_addr), .stage_din(stage_din),
    .stage_we(stage_we), .stage_done(stage_done),
    .stage_start(stage_start), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_we(bram_we), .active_stage(active_stage), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NS; i++) begin
      a[i]  = AW'($urandom);
      dv[i] = DW'($urandom);
      w[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NS; i++) begin
      stage_addr[i*AW +: AW] = a[i];
      stage_din[i*DW +: DW]  = dv[i];
    end
    stage_we   = w;
    stage_done = done_r;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b1; done_r = '0;
    rand_inputs(); w = '1; apply();
    tick(); tick(); #1;
    checks++; if (stage_start !== 3'b000) begin failures++; $display("FAIL rst_start got=%b exp=000", stage_start); end
    checks++; if (active_stage !== 2'd2) begin failures++; $display("FAIL rst_active got=%0d exp=2", active_stage); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
    checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", bram_we); end
    checks++; if (bram_addr !== a[2]) begin failures++; $display("FAIL rst_addr got=%h exp=%h", bram_addr, a[2]); end
    tick(); reset = 1'b0; go = 1'b0; #1;
    checks++; if (busy !== 1'b0 || stage_start !== 3'b000) begin failures++; $display("FAIL rst_idle busy=%b start=%b exp=0/000", busy, stage_start); end
  endtask

  // Timeline model: stage k starts at s_k, sees its done edge at e_k = s_k + d_k,
  // the next start lands at e_k + 2, and the terminal stage holds afterwards.
  task automatic run_chain(input int d0, input int d1, input bit stale);
    int s0, e0, s1, e1, s2, own;
    logic [NS-1:0] xs;
    logic [1:0] xa;
    logic xw, xb;
    tick();
    go = 1'b1; done_r = stale ? 3'b001 : 3'b000; rand_inputs(); apply(); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL chain_pre_busy c=%0d got=%b exp=0", cyc, busy); end
    s0 = cyc + 1; e0 = s0 + d0; s1 = e0 + 2; e1 = s1 + d1; s2 = e1 + 2;
    for (int c = s0; c <= s2 + 1; c++) begin
      tick();
      go = 1'b0;
      rand_inputs();
      if (c == s0 + 1) begin a[0] = 19'h00005; dv[0] = 3'b101; w[0] = 1'b1; end
      if (c == s2 + 1) w[2] = 1'b1;
      done_r = '0;
      if (stale && c < e0 - 1) done_r[0] = 1'b1;
      if (c == e0) done_r[0] = 1'b1;
      if (c == e1) done_r[1] = 1'b1;
      apply(); #1;
      own = (c <= e0 + 1) ? 0 : (c <= e1 + 1) ? 1 : 2;
      xa = 2'(own);
      xs = (c == s0) ? 3'b001 : (c == s1) ? 3'b010 : (c == s2) ? 3'b100 : 3'b000;
      xw = 1'b0;
      if (own == 0 && c > s0 && c <= e0) xw = w[0];
      if (own == 1 && c > s1 && c <= e1) xw = w[1];
      xb = (c <= s2);
      checks++; if (stage_start !== xs) begin failures++; $display("FAIL chain_start c=%0d got=%b exp=%b", c - s0, stage_start, xs); end
      checks++; if (active_stage !== xa) begin failures++; $display("FAIL chain_active c=%0d got=%0d exp=%0d", c - s0, active_stage, xa); end
      checks++; if (busy !== xb) begin failures++; $display("FAIL chain_busy c=%0d got=%b exp=%b", c - s0, busy, xb); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL chain_error c=%0d got=%b exp=0", c - s0, error); end
      checks++; if (bram_we !== xw) begin failures++; $display("FAIL chain_we c=%0d got=%b exp=%b", c - s0, bram_we, xw); end
      checks++; if (bram_addr !== a[own]) begin failures++; $display("FAIL chain_addr c=%0d got=%h exp=%h", c - s0, bram_addr, a[own]); end
      checks++; if (bram_din !== dv[own]) begin failures++; $display("FAIL chain_din c=%0d got=%b exp=%b", c - s0, bram_din, dv[own]); end
    end
  endtask

  // Stage 0 never finishes: RUN lasts TO cycles, FAULT from the next one.
  task automatic test_timeout(input bit go_at_fire);
    int s;
    logic xf;
    logic [1:0] xa;
    tick();
    go = 1'b1; done_r = '0; rand_inputs(); apply(); #1;
    s = cyc + 1;
    for (int c = s; c <= s + TO + 2; c++) begin
      tick();
      go = go_at_fire && (c == s + TO);
      rand_inputs(); w = '1; apply(); #1;
      xf = (c > s + TO);
      xa = xf ? 2'd2 : 2'd0;
      checks++; if (error !== xf) begin failures++; $display("FAIL to_error c=%0d got=%b exp=%b", c - s, error, xf); end
      checks++; if (busy !== !xf) begin failures++; $display("FAIL to_busy c=%0d got=%b exp=%b", c - s, busy, !xf); end
      checks++; if (active_stage !== xa) begin failures++; $display("FAIL to_active c=%0d got=%0d exp=%0d", c - s, active_stage, xa); end
      checks++; if (bram_we !== (!xf && c > s)) begin failures++; $display("FAIL to_we c=%0d got=%b exp=%b", c - s, bram_we, (!xf && c > s)); end
      checks++; if (stage_start !== ((c == s) ? 3'b001 : 3'b000)) begin failures++; $display("FAIL to_start c=%0d got=%b", c - s, stage_start); end
    end
    tick(); go = 1'b1; #1;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL to_hold_error got=%b exp=1", error); end
    tick(); go = 1'b0; #1;
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL to_clear_error got=%b exp=0", error); end
    checks++; if (stage_start !== 3'b001) begin failures++; $display("FAIL to_restart got=%b exp=001", stage_start); end
    checks++; if (busy !== 1'b1 || active_stage !== 2'd0) begin failures++; $display("FAIL to_restart_own busy=%b active=%0d exp=1/0", busy, active_stage); end
  endtask

  // Entered in START(0): advance to RUN(1), then go is ignored and reset aborts.
  task automatic test_go_ignored_and_reset();
    tick(); done_r = 3'b001; w = '1; apply(); #1;
    tick(); done_r = 3'b000; apply(); #1;
    tick(); #1;
    checks++; if (stage_start !== 3'b010) begin failures++; $display("FAIL abort_start1 got=%b exp=010", stage_start); end
    tick(); go = 1'b1; #1;
    checks++; if (bram_we !== 1'b1 || active_stage !== 2'd1) begin failures++; $display("FAIL abort_run1 we=%b active=%0d exp=1/1", bram_we, active_stage); end
    tick(); go = 1'b0; #1;
    checks++; if (stage_start !== 3'b000) begin failures++; $display("FAIL abort_go_ignored got=%b exp=000", stage_start); end
    checks++; if (active_stage !== 2'd1 || busy !== 1'b1 || bram_we !== 1'b1) begin failures++; $display("FAIL abort_still_run active=%0d busy=%b we=%b exp=1/1/1", active_stage, busy, bram_we); end
    reset = 1'b1;
    tick(); #1;
    checks++; if (active_stage !== 2'd2) begin failures++; $display("FAIL abort_rst_active got=%0d exp=2", active_stage); end
    checks++; if (bram_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_rst_we we=%b busy=%b exp=0/0", bram_we, busy); end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; done_r = '0;
    rand_inputs(); apply();
    test_reset();
    run_chain(100, $urandom_range(1, TO), 1'b0);
    for (int r = 0; r < 3; r++) run_chain($urandom_range(1, TO), $urandom_range(1, TO), 1'b0);
    run_chain(TO, TO, 1'b0);
    run_chain(1, 1, 1'b0);
    run_chain($urandom_range(3, 20), $urandom_range(1, 20), 1'b1);
    test_timeout(1'b0);
    test_go_ignored_and_reset();
    run_chain($urandom_range(1, 40), $urandom_range(1, 40), 1'b0);
    test_timeout(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
